// File: rtl/add_sub_serial_nbits.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock from LSB to MSB, carrying between chunks,
// with unsigned carry/borrow and signed overflow, behind valid/ready handshakes on both sides.
module add_sub_serial_nbits #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   s_o,
    output logic             ovf_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic               sub_q;
    logic [IDX_W-1:0]   idx_q;

    logic [CHUNK:0]     chunk_sum;
    logic [WIDTH-1:0]   res_next;
    logic               last_chunk;

    always_comb begin
        chunk_sum  = {1'b0, a_q[int'(idx_q)*CHUNK +: CHUNK]}
                   + {1'b0, b_q[int'(idx_q)*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(carry_q);
        res_next   = res_q;
        res_next[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (idx_q == LAST_IDX);
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            s_o         <= '0;
            ovf_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
                        a_q        <= a_i;
                        b_q        <= sub_i ? ~b_i : b_i;
                        carry_q    <= sub_i;
                        sub_q      <= sub_i;
                        idx_q      <= '0;
                        res_q      <= '0;
                        in_ready_o <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    res_q   <= res_next;
                    carry_q <= chunk_sum[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        // Carry out of an A + ~B + 1 sum is the inverse of the borrow.
                        s_o         <= {chunk_sum[CHUNK] ^ sub_q, res_next};
                        ovf_o       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (res_next[WIDTH-1] != a_q[WIDTH-1]);
                        out_valid_o <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_serial_nbits.sv
// Bench for add_sub_serial_nbits: four instances (CHUNK = 1, 2, 4, 8; WIDTH = 8) share the stimulus
// and are compared against an integer-arithmetic model, plus reset and backpressure sequences.
module tb_add_sub_serial_nbits;

    localparam int W  = 8;
    localparam int NI = 4;
    localparam int MAIN = 1;  // instance with CHUNK = 2

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         ovf       [NI];
    logic [W:0]   s         [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        add_sub_serial_nbits #(
            .WIDTH(W),
            .CHUNK(1 << g)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[g]),
            .a_i        (a),
            .b_i        (b),
            .sub_i      (sub),
            .s_o        (s[g]),
            .ovf_o      (ovf[g]),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready)
        );
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W:0]   s;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W:0] ms, output logic movf);
        int ua, ub, sa, sb, r;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        r  = msub ? sa - sb : sa + sb;
        ms   = msub ? (W+1)'(ua - ub) : (W+1)'(ua + ub);
        movf = (r > 127) || (r < -128);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vsub, input logic [W:0] exp_s, input logic exp_ovf);
        int         lat  [NI];
        int         vcnt [NI];
        logic [W:0] got_s[NI];
        logic       got_o[NI];
        logic [W:0] held;
        bit         held_ok;
        held    = s[MAIN];
        held_ok = 1'b1;
        for (int i = 0; i < NI; i++) begin
            lat[i]   = 0;
            vcnt[i]  = 0;
            got_s[i] = 'x;
            got_o[i] = 1'bx;
        end
        @(negedge clk);
        a = va; b = vb; sub = vsub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i]) begin
                    vcnt[i]++;
                    if (lat[i] == 0) begin
                        lat[i]   = c;
                        got_s[i] = s[i];
                        got_o[i] = ovf[i];
                    end
                end else if (i == MAIN && lat[i] == 0 && s[i] !== held) begin
                    held_ok = 1'b0;
                end
            end
        end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s ch%0d latency", tag, 1 << i), lat[i], 8 >> i);
            check($sformatf("%s ch%0d valid_cycles", tag, 1 << i), vcnt[i], 1);
            check($sformatf("%s ch%0d s", tag, 1 << i), 32'(got_s[i]), 32'(exp_s));
            check($sformatf("%s ch%0d ovf", tag, 1 << i), 32'(got_o[i]), 32'(exp_ovf));
        end
        check($sformatf("%s s_held_during_calc", tag), 32'(held_ok), 32'd1);
    endtask

    task automatic wait_all_idle(input string tag);
        bit all_idle;
        all_idle = 1'b0;
        for (int c = 0; c < 20 && !all_idle; c++) begin
            @(posedge clk);
            #1;
            all_idle = 1'b1;
            for (int i = 0; i < NI; i++) if (!in_ready[i]) all_idle = 1'b0;
        end
        check({tag, " all_idle"}, 32'(all_idle), 32'd1);
    endtask

    initial begin
        vec_t         vecs[6];
        logic [W:0]   ms;
        logic         movf;
        logic [W-1:0] ra, rb;
        logic         rs;
        bit           rose;

        vecs[0] = '{"add_200_100", 8'd200,  8'd100, 1'b0, 9'h12C, 1'b0};
        vecs[1] = '{"add_100_100", 8'd100,  8'd100, 1'b0, 9'h0C8, 1'b1};
        vecs[2] = '{"add_7f_1",    8'h7F,   8'h01,  1'b0, 9'h080, 1'b1};
        vecs[3] = '{"sub_5_10",    8'd5,    8'd10,  1'b1, 9'h1FB, 1'b0};
        vecs[4] = '{"sub_80_1",    8'h80,   8'h01,  1'b1, 9'h07F, 1'b1};
        vecs[5] = '{"sub_10_10",   8'd10,   8'd10,  1'b1, 9'h000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
        #12;
        check("reset s", 32'(s[MAIN]), 32'd0);
        check("reset ovf", 32'(ovf[MAIN]), 32'd0);
        check("reset in_ready", 32'(in_ready[MAIN]), 32'd1);
        check("reset out_valid", 32'(out_valid[MAIN]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].ovf);

        // Backpressure: result held while out_ready is low, extra in_valid pulses ignored.
        out_ready = 1'b0;
        model(8'h55, 8'h33, 1'b0, ms, movf);
        @(negedge clk);
        a = 8'h55; b = 8'h33; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !out_valid[MAIN]; c++) begin
            @(posedge clk);
            #1;
        end
        check("bp valid", 32'(out_valid[MAIN]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = ~in_valid;
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d valid", c), 32'(out_valid[MAIN]), 32'd1);
            check($sformatf("bp hold%0d s", c), 32'(s[MAIN]), 32'(ms));
            check($sformatf("bp hold%0d ovf", c), 32'(ovf[MAIN]), 32'(movf));
            check($sformatf("bp hold%0d in_ready", c), 32'(in_ready[MAIN]), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp drain out_valid", 32'(out_valid[MAIN]), 32'd0);
        check("bp drain in_ready", 32'(in_ready[MAIN]), 32'd1);
        check("bp drain s_kept", 32'(s[MAIN]), 32'(ms));
        wait_all_idle("bp");
        rose = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[MAIN]) rose = 1'b1;
        end
        check("bp no_second_op", 32'(rose), 32'd0);

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, ms, movf);
            run_op($sformatf("rnd%0d", n), ra, rb, rs, ms, movf);
        end

        // Reset during CALC discards the operation.
        run_op("pre_reset", 8'd200, 8'd100, 1'b0, 9'h12C, 1'b0);
        @(negedge clk);
        a = 8'd77; b = 8'd33; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset s", 32'(s[MAIN]), 32'd0);
        check("mid_reset ovf", 32'(ovf[MAIN]), 32'd0);
        check("mid_reset in_ready", 32'(in_ready[MAIN]), 32'd1);
        check("mid_reset out_valid", 32'(out_valid[MAIN]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rose = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (out_valid[i]) rose = 1'b1;
                if (!in_ready[i]) rose = 1'b1;
            end
        end
        check("mid_reset no_output", 32'(rose), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
